// File: rtl/compositor_pkg.sv
// Shared types and helpers for the sprite compositor pixel stage.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package compositor_pkg;

    // Final-stage colour, {R,G,B} byte order.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_FULL,
        ST_FADE_OUT,
        ST_DARK,
        ST_FADE_IN
    } fade_state_e;

    localparam int FADE_MAX = 16;
    localparam int LEVEL_W  = 5;    // holds 0..FADE_MAX inclusive

    // Pairs (i<j) are numbered i-major: 0-1, 0-2, .., (L-2)-(L-1).
    function automatic int pair_idx(input int i, input int j, input int layers);
        return i * (2 * layers - i - 1) / 2 + (j - i - 1);
    endfunction

    // Sprite stages emit {R,B,G}; swap the low two bytes into {R,G,B}.
    function automatic rgb_t rbg_to_rgb(input logic [23:0] rbg);
        rgb_t c;
        c.r = rbg[23:16];
        c.b = rbg[15:8];
        c.g = rbg[7:0];
        return c;
    endfunction

    // (c * level) >> 4; the 13-bit product cannot exceed 255*16, so no saturation.
    function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [LEVEL_W-1:0] lvl);
        logic [12:0] prod;
        prod = {5'd0, c} * {8'd0, lvl};
        return 8'(prod >> 4);
    endfunction

endpackage

// File: rtl/collision_tracker.sv
// Per-frame sprite-pair collision accumulator with frame-boundary report.
// Latency: report registered 1 cycle after i_frame; o_coll_valid is a 1-cycle pulse.
// Backpressure: none; accepts one pixel per cycle unconditionally.
//
// Ports: i_opaque (per-layer opaque), i_de, i_frame -> o_collision (NPAIRS flags of the
// last complete frame), o_coll_valid. Clock i_clk_pix, sync active-low reset i_rst_n.
module collision_tracker
    import compositor_pkg::*;
#(
    parameter int LAYERS = 4,
    parameter int NPAIRS = LAYERS * (LAYERS - 1) / 2
) (
    input  logic              i_clk_pix,
    input  logic              i_rst_n,
    input  logic [LAYERS-1:0] i_opaque,
    input  logic              i_de,
    input  logic              i_frame,
    output logic [NPAIRS-1:0] o_collision,
    output logic              o_coll_valid
);

    logic [NPAIRS-1:0] hits;
    logic [NPAIRS-1:0] acc;

    for (genvar gi = 0; gi < LAYERS - 1; gi++) begin : g_i
        for (genvar gj = gi + 1; gj < LAYERS; gj++) begin : g_j
            assign hits[pair_idx(gi, gj, LAYERS)] = i_de & i_opaque[gi] & i_opaque[gj];
        end
    end

    // Hits seen on the i_frame cycle belong to the frame being closed, so they are
    // folded into the report and the accumulator restarts clean.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            acc          <= '0;
            o_collision  <= '0;
            o_coll_valid <= 1'b0;
        end else begin
            o_coll_valid <= i_frame;
            if (i_frame) begin
                o_collision <= acc | hits;
                acc         <= '0;
            end else begin
                acc <= acc | hits;
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Final pixel stage: priority-merges LAYERS sprites over a background, delay-matches syncs.
// Latency: 2 cycles from inputs to o_r/o_g/o_b and o_hsync/o_vsync/o_de.
// Backpressure: none; free-running pixel stream, one pixel per i_clk_pix.
//
// Ports: i_frame/i_hsync/i_vsync/i_de timing; i_bg_color {R,G,B}; per-layer i_layer_en,
// i_layer_drawing, i_layer_trans, i_layer_color ({R,B,G} per layer, layer i at [i*24+:24]);
// i_fade_req. Outputs: delayed syncs, o_r/o_g/o_b, o_collision/o_coll_valid.
// Optional: define SPRITE_COMPOSITOR_FADE_EN for frame-stepped fade out/in of all colour.
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter  int LAYERS    = 4,
    parameter  int FADE_STEP = 4,
    localparam int NPAIRS    = LAYERS * (LAYERS - 1) / 2
) (
    input  logic                 i_clk_pix,
    input  logic                 i_rst_n,
    input  logic                 i_frame,
    input  logic                 i_hsync,
    input  logic                 i_vsync,
    input  logic                 i_de,
    input  logic [23:0]          i_bg_color,
    input  logic [LAYERS-1:0]    i_layer_en,
    input  logic [LAYERS-1:0]    i_layer_drawing,
    input  logic [LAYERS-1:0]    i_layer_trans,
    input  logic [LAYERS*24-1:0] i_layer_color,
    input  logic                 i_fade_req,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [7:0]           o_r,
    output logic [7:0]           o_g,
    output logic [7:0]           o_b,
    output logic [NPAIRS-1:0]    o_collision,
    output logic                 o_coll_valid
);

    logic [LAYERS-1:0] opaque;
    rgb_t              win_color;
    rgb_t              s1_color;
    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_de;
    rgb_t              s2_color;

    assign opaque = i_layer_drawing & ~i_layer_trans & i_layer_en;

    // Walk from back to front so the lowest-index opaque layer is written last and wins.
    always_comb begin
        win_color = rgb_t'(i_bg_color);
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_color = rbg_to_rgb(i_layer_color[i*24 +: 24]);
            end
        end
    end

    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            s1_color <= '0;
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
        end else begin
            s1_color <= win_color;
            s1_hsync <= i_hsync;
            s1_vsync <= i_vsync;
            s1_de    <= i_de;
        end
    end

`ifdef SPRITE_COMPOSITOR_FADE_EN
    localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    fade_state_e        fade_state;
    logic [LEVEL_W-1:0] fade_level;
    logic [STEP_W-1:0]  step_cnt;

    // Everything advances only on frame boundaries so a frame is never split across levels.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            fade_state <= ST_FULL;
            fade_level <= LEVEL_W'(FADE_MAX);
            step_cnt   <= '0;
        end else if (i_frame) begin
            case (fade_state)
                ST_FULL: begin
                    if (i_fade_req) begin
                        fade_state <= ST_FADE_OUT;
                        step_cnt   <= '0;
                    end
                end
                ST_FADE_OUT: begin
                    if (step_cnt == STEP_W'(FADE_STEP - 1)) begin
                        step_cnt   <= '0;
                        fade_level <= fade_level - 1'b1;
                        if (fade_level == LEVEL_W'(1)) begin
                            fade_state <= ST_DARK;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_DARK: begin
                    if (i_fade_req) begin
                        fade_state <= ST_FADE_IN;
                        step_cnt   <= '0;
                    end
                end
                ST_FADE_IN: begin
                    if (step_cnt == STEP_W'(FADE_STEP - 1)) begin
                        step_cnt   <= '0;
                        fade_level <= fade_level + 1'b1;
                        if (fade_level == LEVEL_W'(FADE_MAX - 1)) begin
                            fade_state <= ST_FULL;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: fade_state <= ST_FULL;
            endcase
        end
    end

    always_comb begin
        s2_color.r = fade_scale(s1_color.r, fade_level);
        s2_color.g = fade_scale(s1_color.g, fade_level);
        s2_color.b = fade_scale(s1_color.b, fade_level);
    end
`else
    logic [31:0] unused_fade;
    assign unused_fade = {FADE_STEP[30:0], i_fade_req};
    assign s2_color    = s1_color;
`endif

    // Blank colour outside the active area so the encoder sees clean black.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
        end else begin
            o_hsync <= s1_hsync;
            o_vsync <= s1_vsync;
            o_de    <= s1_de;
            if (s1_de) begin
                o_r <= s2_color.r;
                o_g <= s2_color.g;
                o_b <= s2_color.b;
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end

    collision_tracker #(
        .LAYERS (LAYERS),
        .NPAIRS (NPAIRS)
    ) u_collision_tracker (
        .i_clk_pix    (i_clk_pix),
        .i_rst_n      (i_rst_n),
        .i_opaque     (opaque),
        .i_de         (i_de),
        .i_frame      (i_frame),
        .o_collision  (o_collision),
        .o_coll_valid (o_coll_valid)
    );

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels push hand-computed expectations,
// a negedge monitor pops and compares pixel and collision outputs each cycle.
// Fade sequence is exercised only when SPRITE_COMPOSITOR_FADE_EN is defined.
module tb_sprite_compositor;

    localparam int L  = 4;
    localparam int NP = L * (L - 1) / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame = 1'b0;
    logic          hsync = 1'b0;
    logic          vsync = 1'b0;
    logic          de = 1'b0;
    logic [23:0]   bg = 24'h0;
    logic [L-1:0]  en = '0;
    logic [L-1:0]  drw = '0;
    logic [L-1:0]  trans = '0;
    logic [L*24-1:0] lc = '0;
    logic          fade_req = 1'b0;
    logic          o_hsync, o_vsync, o_de;
    logic [7:0]    o_r, o_g, o_b;
    logic [NP-1:0] o_collision;
    logic          o_coll_valid;

    sprite_compositor #(
        .LAYERS    (L),
        .FADE_STEP (1)
    ) dut (
        .i_clk_pix       (clk),
        .i_rst_n         (rst_n),
        .i_frame         (frame),
        .i_hsync         (hsync),
        .i_vsync         (vsync),
        .i_de            (de),
        .i_bg_color      (bg),
        .i_layer_en      (en),
        .i_layer_drawing (drw),
        .i_layer_trans   (trans),
        .i_layer_color   (lc),
        .i_fade_req      (fade_req),
        .o_hsync         (o_hsync),
        .o_vsync         (o_vsync),
        .o_de            (o_de),
        .o_r             (o_r),
        .o_g             (o_g),
        .o_b             (o_b),
        .o_collision     (o_collision),
        .o_coll_valid    (o_coll_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [26:0] v;     // {hs, vs, de, r, g, b}
    } px_exp_t;

    typedef struct {
        int              due;
        logic [NP:0]     v; // {coll_valid, collision}
    } coll_exp_t;

    px_exp_t   px_q[$];
    coll_exp_t coll_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    // ---------------- monitor ----------------
    px_exp_t   pe_m;
    coll_exp_t ce_m;
    always @(negedge clk) begin
        while (px_q.size() > 0 && px_q[0].due < cyc) begin
            pe_m = px_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL pixel_missed due=%0d now=%0d exp=%h", pe_m.due, cyc, pe_m.v);
        end
        if (px_q.size() > 0 && px_q[0].due == cyc) begin
            pe_m = px_q.pop_front();
            n_checks++;
            if ({o_hsync, o_vsync, o_de, o_r, o_g, o_b} !== pe_m.v) begin
                n_fail++;
                $display("FAIL pixel cyc=%0d got=%h exp=%h", cyc,
                         {o_hsync, o_vsync, o_de, o_r, o_g, o_b}, pe_m.v);
            end
        end
        while (coll_q.size() > 0 && coll_q[0].due < cyc) begin
            ce_m = coll_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL coll_missed due=%0d now=%0d exp=%b", ce_m.due, cyc, ce_m.v);
        end
        if (coll_q.size() > 0 && coll_q[0].due == cyc) begin
            ce_m = coll_q.pop_front();
            n_checks++;
            if ({o_coll_valid, o_collision} !== ce_m.v) begin
                n_fail++;
                $display("FAIL collision cyc=%0d got=%b exp=%b", cyc,
                         {o_coll_valid, o_collision}, ce_m.v);
            end
        end else begin
            n_checks++;
            if (o_coll_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL coll_valid_spurious cyc=%0d got=%b exp=0", cyc, o_coll_valid);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lc(input logic [23:0] c0, input logic [23:0] c1,
                          input logic [23:0] c2, input logic [23:0] c3);
        lc = {c3, c2, c1, c0};
    endtask

    // Drive one pixel; exp_rgb is the hand-computed {R,G,B} expected two cycles later.
    task automatic pix(input logic hs, input logic vs, input logic d,
                       input logic [L-1:0] e, input logic [L-1:0] dr, input logic [L-1:0] tr,
                       input logic [23:0] exp_rgb);
        px_exp_t pe;
        hsync = hs;
        vsync = vs;
        de    = d;
        en    = e;
        drw   = dr;
        trans = tr;
        pe.due = cyc + 2;
        pe.v   = {hs, vs, d, exp_rgb};
        px_q.push_back(pe);
        tick();
        frame = 1'b0;
    endtask

    task automatic expect_coll(input logic vld, input logic [NP-1:0] c);
        coll_exp_t ce;
        ce.due = cyc + 1;
        ce.v   = {vld, c};
        coll_q.push_back(ce);
    endtask

    // Assert reset for n cycles; inputs keep whatever the last pixel drove.
    task automatic reset_cycles(input int n);
        px_exp_t pe;
        rst_n = 1'b0;
        while (px_q.size() > 0 && px_q[$].due > cyc) void'(px_q.pop_back());
        while (coll_q.size() > 0 && coll_q[$].due > cyc) void'(coll_q.pop_back());
        for (int k = 0; k < n; k++) begin
            pe.due = cyc + 1;
            pe.v   = '0;
            px_q.push_back(pe);
            expect_coll(1'b0, '0);
            tick();
        end
    endtask

    // Release reset; the first post-reset output still comes from the cleared stage 1.
    task automatic reset_release();
        px_exp_t pe;
        rst_n  = 1'b1;
        pe.due = cyc + 1;
        pe.v   = '0;
        px_q.push_back(pe);
    endtask

    task automatic frame_pulse(input logic [NP-1:0] exp_c);
        frame = 1'b1;
        expect_coll(1'b1, exp_c);
        pix(1'b0, 1'b1, 1'b0, '0, '0, '0, 24'h0);
    endtask

`ifdef SPRITE_COMPOSITOR_FADE_EN
    // One frame boundary, then an active background pixel scaled by the expected level.
    task automatic fade_frame(input logic req, input int lvl);
        logic [7:0] r;
        r        = 8'((128 * lvl) >> 4);
        fade_req = req;
        frame_pulse('0);
        pix(1'b0, 1'b0, 1'b0, '0, '0, '0, 24'h0);
        pix(1'b0, 1'b0, 1'b1, '0, '0, '0, {r, 16'h0000});
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        tick();
        reset_cycles(3);
        bg = 24'h0A0B0C;
        reset_release();

        // Priority: L0 over L1, {R,B,G} -> {R,G,B}
        set_lc(24'hFF0000, 24'h00FF00, 24'h000000, 24'h778899);
        pix(0, 0, 1, 4'hF, 4'b0011, 4'b0000, 24'hFF0000);
        pix(0, 0, 1, 4'hF, 4'b0010, 4'b0000, 24'h0000FF);
        set_lc(24'h445566, 24'h112233, 24'h000000, 24'h778899);
        pix(0, 0, 1, 4'hF, 4'b0011, 4'b0001, 24'h113322);
        pix(0, 0, 1, 4'hF, 4'b0001, 4'b0000, 24'h446655);
        pix(0, 0, 1, 4'hF, 4'b0000, 4'b0000, 24'h0A0B0C);
        pix(0, 0, 1, 4'hF, 4'b1111, 4'b1111, 24'h0A0B0C);
        pix(0, 0, 1, 4'b1110, 4'b0001, 4'b0000, 24'h0A0B0C);
        pix(0, 0, 1, 4'hF, 4'b1000, 4'b0000, 24'h779988);

        // DE gating and sync delay-matching
        pix(1, 0, 0, 4'hF, 4'b0001, 4'b0000, 24'h000000);
        pix(0, 0, 0, 4'hF, 4'b0001, 4'b0000, 24'h000000);
        pix(1, 1, 0, 4'hF, 4'b0001, 4'b0000, 24'h000000);
        pix(1, 0, 1, 4'hF, 4'b0001, 4'b0000, 24'h446655);
        pix(0, 1, 0, 4'hF, 4'b0001, 4'b0000, 24'h000000);

        // Close the frame: only the first pixel had L0 & L1 overlapping
        frame_pulse(6'b000001);

        // Frame N: L0 & L2 overlap 5 px; masked overlaps must not flag
        set_lc(24'hAA0000, 24'h123456, 24'h0000CC, 24'h778899);
        repeat (5) pix(0, 0, 1, 4'hF, 4'b0101, 4'b0000, 24'hAA0000);
        pix(0, 0, 1, 4'b1110, 4'b0101, 4'b0000, 24'h00CC00);
        pix(0, 0, 0, 4'hF, 4'b0101, 4'b0000, 24'h000000);
        pix(0, 0, 1, 4'hF, 4'b0110, 4'b0010, 24'h00CC00);
        frame_pulse(6'b000010);

        // Frame N+1 clean
        pix(0, 0, 1, 4'hF, 4'b0100, 4'b0000, 24'h00CC00);
        frame_pulse(6'b000000);

        // Hit on the i_frame cycle itself belongs to the closing frame (pair 1-3)
        pix(0, 0, 1, 4'hF, 4'b0100, 4'b0000, 24'h00CC00);
        frame = 1'b1;
        expect_coll(1'b1, 6'b010000);
        pix(0, 0, 1, 4'hF, 4'b1010, 4'b0000, 24'h125634);

        // Mid-frame reset with hits pending: everything clears, next report is 0
        pix(0, 0, 1, 4'hF, 4'b0011, 4'b0000, 24'hAA0000);
        pix(1, 1, 1, 4'hF, 4'b0011, 4'b0000, 24'hAA0000);
        reset_cycles(3);
        reset_release();
        pix(0, 0, 1, 4'hF, 4'b0000, 4'b0000, 24'h0A0B0C);
        pix(0, 0, 1, 4'hF, 4'b0000, 4'b0000, 24'h0A0B0C);
        frame_pulse(6'b000000);

`ifdef SPRITE_COMPOSITOR_FADE_EN
        bg = 24'h800000;
        fade_frame(1'b1, 16);                               // FULL -> FADE_OUT
        for (int k = 1; k <= 16; k++) fade_frame(1'b1, 16 - k); // req held: ignored
        fade_frame(1'b0, 0);                                // stays DARK
        fade_frame(1'b1, 0);                                // DARK -> FADE_IN
        for (int k = 1; k <= 16; k++) fade_frame(1'b1, k);
        fade_frame(1'b0, 16);                               // stays FULL
`endif

        repeat (3) pix(0, 0, 0, '0, '0, '0, 24'h000000);
        repeat (3) tick();
        n_checks++;
        if (px_q.size() != 0 || coll_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pixel_left=%0d coll_left=%0d required=0", px_q.size(), coll_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
